pio_deb_irq: RTL and testbench
==============================

Name: pio_deb_irq

Overview:
Parametrised next-generation Avalon-MM PIO slave for the HPS lightweight bridge. It provides per-bit direction control, atomic set/clear of the output register, and a configurable input synchroniser. Each input bit is debounced and has its own rising- and falling-edge capture enables, with a maskable, level-sensitive IRQ. It replaces fixed 32-bit, rising-edge-only PIO instances for LED and switch/key I/O.

Parameters:
DATA_W, 32, number of I/O bits (1..32); writedata bits above DATA_W ignored, readdata zero-extended
SYNC_STAGES, 2, input synchroniser flops per bit (2..4)
DEB_W, 16, width of per-bit debounce counters and of the threshold register (1..16)
RESET_OUT, 0, reset value of data_out (DATA_W bits)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  4  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
in_port  in  DATA_W  asynchronous external inputs
out_port  out  DATA_W  data_out register
out_en  out  DATA_W  direction register, 1 = bit driven
irq  out  1  interrupt request, level

Behaviour:
- Reset values: all registers 0 except data_out = RESET_OUT; outputs readdata=0, out_port=RESET_OUT, out_en=0, irq=0.
- Write strobe: wr = chipselect & ~write_n. Reads have no side effects. Writes to unlisted addresses are ignored.
- readdata: registered every clk, 1-cycle latency, independent of chipselect.
- Register map (W = write, R = read):
  - 0 DATA: W data_out <= wd. R (db & ~dir) | (data_out & dir).
  - 1 DIR: R/W.
  - 2 IRQ_MASK: R/W.
  - 3 EDGE_CAP: R; W1C per bit.
  - 4 OUTSET: W data_out |= wd; R data_out.
  - 5 OUTCLR: W data_out &= ~wd; R data_out.
  - 6 RISE_EN: R/W.
  - 7 FALL_EN: R/W.
  - 8 DEB_THR: R/W, DEB_W bits.
  - 9 RAW: R synchronised input s, pre-debounce.
  - 10..15: R 0.
- Synchroniser: s = in_port delayed by SYNC_STAGES flops.
- Debounce, per bit i, using counter cnt[i] and stable value db[i]:
  - s==db: cnt <= 0.
  - s!=db and DEB_THR==0: db <= s next edge (bypass).
  - s!=db and cnt==DEB_THR-1: db <= s, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - A glitch shorter than DEB_THR cycles never reaches db. Writing DEB_THR mid-count takes effect immediately; cnt is not cleared.
- Edge detect: db_d <= db each clk; rise = db & ~db_d; fall = ~db & db_d; ev = (rise & RISE_EN) | (fall & FALL_EN).
- EDGE_CAP[i]: set when ev[i]; cleared by W1C to addr 3. Same-cycle clear and ev: set wins, so no lost event.
- irq = |(EDGE_CAP & IRQ_MASK), combinational from registers. Stays high until all masked captured bits are cleared.
- Latency, with a change on in_port before edge 0, S=SYNC_STAGES, T=DEB_THR:
  - s changes at edge S.
  - db at edge S+max(T,1).
  - EDGE_CAP and irq at edge S+max(T,1)+1.
- Inputs held high at reset generate a rising event after reset. Software clears EDGE_CAP before unmasking.
- Reset asserted mid-operation clears counters, sync chain, and captures immediately. No event is produced by reset itself.

Test Plan:
1. Reset with in_port=0 → readdata=0, out_port=RESET_OUT, out_en=0, irq=0; read all 16 addresses → only defined bits nonzero after writes.
2. Write addr0=0xFFFF0000, addr4=0x0000000F, addr5=0x00030000 → out_port=0xFFFC000F; read addr4 one cycle after → 0xFFFC000F.
3. DEB_THR=0, RISE_EN=1, IRQ_MASK=1, in_port[0] 0→1 → EDGE_CAP=0x1 and irq=1 exactly S+2 edges later; W1C 0x1 → irq=0 next cycle.
4. DEB_THR=5, FALL_EN[3]=1, in_port[3] high then 4-cycle low pulse → no capture. 5-cycle low → EDGE_CAP[3]=1 at edge S+6 after fall.
5. Pulse arranged so the ev cycle coincides with a W1C write of the same bit → EDGE_CAP bit remains 1.
6. DIR=0x0000FFFF, data_out=0x00001234, in_port=0xABCD0000 → addr0 read = 0xABCD1234; reset_n pulsed mid-debounce → all cleared, no spurious capture.

Source files
------------

// File: rtl/pio_deb_irq.sv
// Avalon-MM PIO slave: per-bit direction, atomic set/clear outputs,
// synchronised and debounced inputs with per-bit edge capture and a maskable level IRQ.
module pio_deb_irq #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_W       = 16,
  parameter logic [31:0] RESET_OUT   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] out_en,
  output logic              irq
);

  localparam logic [DATA_W-1:0] RST_OUT = RESET_OUT[DATA_W-1:0];

  logic [SYNC_STAGES-1:0][DATA_W-1:0] r_sync;
  logic [DATA_W-1:0] r_data, r_dir, r_mask, r_cap, r_rise, r_fall;
  logic [DATA_W-1:0] r_db, r_db_d;
  logic [DEB_W-1:0]  r_thr;
  logic [DEB_W-1:0]  r_cnt [DATA_W];
  logic [31:0]       r_rdata;

  logic              w_wr;
  logic [DATA_W-1:0] w_wd, w_s, w_ev, w_w1c;
  logic [DEB_W-1:0]  w_thr_m1;
  logic [31:0]       w_rd;

  assign w_wr     = chipselect & ~write_n;
  assign w_wd     = writedata[DATA_W-1:0];
  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_thr_m1 = r_thr - DEB_W'(1);
  assign w_ev     = (r_db & ~r_db_d & r_rise) | (~r_db & r_db_d & r_fall);
  assign w_w1c    = (w_wr && address == 4'd3) ? w_wd : '0;

  // Input synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
  end

  // Software-visible control registers; captures favour a new event over a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RST_OUT;
      r_dir  <= '0;
      r_mask <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_thr  <= '0;
      r_cap  <= '0;
    end else begin
      r_cap <= (r_cap & ~w_w1c) | w_ev;
      if (w_wr) begin
        case (address)
          4'd0: r_data <= w_wd;
          4'd1: r_dir  <= w_wd;
          4'd2: r_mask <= w_wd;
          4'd4: r_data <= r_data | w_wd;
          4'd5: r_data <= r_data & ~w_wd;
          4'd6: r_rise <= w_wd;
          4'd7: r_fall <= w_wd;
          4'd8: r_thr  <= writedata[DEB_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Per-bit debounce: db follows s only after it has differed for DEB_THR cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db   <= '0;
      r_db_d <= '0;
      for (int i = 0; i < DATA_W; i++) r_cnt[i] <= '0;
    end else begin
      r_db_d <= r_db;
      for (int i = 0; i < DATA_W; i++) begin
        if (w_s[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_thr == '0) begin
          r_db[i] <= w_s[i];
        end else if (r_cnt[i] == w_thr_m1) begin
          r_db[i]  <= w_s[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Read mux
  always_comb begin
    w_rd = '0;
    case (address)
      4'd0:    w_rd = 32'((r_db & ~r_dir) | (r_data & r_dir));
      4'd1:    w_rd = 32'(r_dir);
      4'd2:    w_rd = 32'(r_mask);
      4'd3:    w_rd = 32'(r_cap);
      4'd4:    w_rd = 32'(r_data);
      4'd5:    w_rd = 32'(r_data);
      4'd6:    w_rd = 32'(r_rise);
      4'd7:    w_rd = 32'(r_fall);
      4'd8:    w_rd = 32'(r_thr);
      4'd9:    w_rd = 32'(w_s);
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rdata <= '0;
    else          r_rdata <= w_rd;
  end

  assign readdata = r_rdata;
  assign out_port = r_data;
  assign out_en   = r_dir;
  assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_pio_deb_irq.sv
// Directed bench for pio_deb_irq with a read-data scoreboard queue.
module tb_pio_deb_irq;

  localparam int unsigned DW  = 32;
  localparam int unsigned S   = 2;
  localparam logic [31:0] RST = 32'h0000_00A5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] in_port;
  logic [DW-1:0] out_port;
  logic [DW-1:0] out_en;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb[$];

  pio_deb_irq #(.DATA_W(DW), .SYNC_STAGES(S), .DEB_W(16), .RESET_OUT(RST)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .out_en(out_en), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] e;
    address = a; chipselect = 1'b1;
    sb.push_back(exp);
    tick();
    chipselect = 1'b0;
    e = sb.pop_front();
    chk(tag, readdata, e);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    repeat (2) tick();
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_out_port", out_port, RST);
    chk("rst_out_en", out_en, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Unlisted addresses ignore writes; map reads back reset values
    for (int a = 10; a < 16; a++) wr(4'(a), 32'hFFFF_FFFF);
    for (int a = 0; a < 16; a++)
      rd($sformatf("map_rst_a%0d", a), 4'(a), (a == 4 || a == 5) ? RST : 32'h0);

    // Output register write / set / clear
    wr(4'd0, 32'hFFFF_0000);
    wr(4'd4, 32'h0000_000F);
    wr(4'd5, 32'h0003_0000);
    chk("out_port_setclr", out_port, 32'hFFFC_000F);
    rd("rd_outset", 4'd4, 32'hFFFC_000F);
    rd("rd_outclr", 4'd5, 32'hFFFC_000F);

    // Bypass debounce: rising edge latency is S+2 edges
    wr(4'd6, 32'h1);
    wr(4'd2, 32'h1);
    rd("rd_rise_en", 4'd6, 32'h1);
    rd("rd_mask", 4'd2, 32'h1);
    in_port[0] = 1'b1;
    repeat (S + 1) tick();
    chk("rise_irq_early", {31'h0, irq}, 32'h0);
    tick();
    chk("rise_irq_on_time", {31'h0, irq}, 32'h1);
    rd("rise_cap", 4'd3, 32'h1);
    wr(4'd3, 32'h1);
    tick();
    chk("w1c_irq_low", {31'h0, irq}, 32'h0);
    rd("w1c_cap", 4'd3, 32'h0);

    // Debounce threshold 5 on bit 3 falling edges
    wr(4'd8, 32'h5);
    wr(4'd7, 32'h8);
    wr(4'd2, 32'h9);
    rd("rd_thr", 4'd8, 32'h5);
    rd("rd_fall_en", 4'd7, 32'h8);
    in_port[3] = 1'b1;
    repeat (S + 10) tick();
    wr(4'd3, 32'hFFFF_FFFF);
    rd("settle_cap", 4'd3, 32'h0);
    in_port[3] = 1'b0;
    repeat (4) tick();
    in_port[3] = 1'b1;
    repeat (S + 12) tick();
    rd("glitch4_cap", 4'd3, 32'h0);
    chk("glitch4_irq", {31'h0, irq}, 32'h0);
    in_port[3] = 1'b0;
    repeat (5) tick();
    in_port[3] = 1'b1;
    tick(); tick();
    chk("pulse5_irq_early", {31'h0, irq}, 32'h0);
    tick();
    chk("pulse5_irq_on_time", {31'h0, irq}, 32'h1);
    rd("pulse5_cap", 4'd3, 32'h8);
    repeat (S + 10) tick();
    rd("raw_in", 4'd9, 32'h9);

    // W1C on the same edge as a new capture keeps the bit set
    wr(4'd3, 32'h8);
    rd("pre_race_cap", 4'd3, 32'h0);
    in_port[3] = 1'b0;
    repeat (S + 5) tick();
    wr(4'd3, 32'h8);
    chk("race_irq", {31'h0, irq}, 32'h1);
    rd("race_cap", 4'd3, 32'h8);
    wr(4'd3, 32'h8);
    rd("race_clear", 4'd3, 32'h0);

    // Mixed direction readback, then reset mid-debounce
    wr(4'd1, 32'h0000_FFFF);
    wr(4'd0, 32'h0000_1234);
    in_port = 32'hABCD_0000;
    repeat (S + 10) tick();
    chk("dir_out_en", out_en, 32'h0000_FFFF);
    chk("dir_out_port", out_port, 32'h0000_1234);
    rd("mixed_data", 4'd0, 32'hABCD_1234);
    wr(4'd6, 32'hFFFF_FFFF);
    wr(4'd7, 32'hFFFF_FFFF);
    wr(4'd2, 32'hFFFF_FFFF);
    wr(4'd3, 32'hFFFF_FFFF);
    in_port = 32'h0000_00F0;
    repeat (S + 2) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_readdata", readdata, 32'h0);
    chk("midrst_out_port", out_port, RST);
    chk("midrst_out_en", out_en, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (S + 4) tick();
    rd("postrst_cap", 4'd3, 32'h0);
    rd("postrst_thr", 4'd8, 32'h0);
    rd("postrst_data", 4'd0, 32'h0000_00F0);
    chk("postrst_irq", {31'h0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
